// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array datapath (Q7.25 partial sums).
package sa_pkg;
  localparam int SA_W = 32;
  localparam int FRAC = 25;
  localparam int SA_N = 4;

  typedef logic signed [SA_W-1:0] psum_t;

  localparam psum_t ONE  = 32'h0200_0000;
  localparam psum_t ZERO = '0;
endpackage

// File: rtl/sa_sync_fifo.sv
// First-word fall-through synchronous FIFO; rdata shows the head entry, 0 when empty.
module sa_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Callers only pop when non-empty and only push when there is room (or a pop frees it).
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/sa_psum_collector.sv
// Deskews the array's bottom-row partial sums into aligned rows, applies optional ReLU,
// and buffers them in a FWFT FIFO behind a valid/ready output.
module sa_psum_collector
  import sa_pkg::*;
#(
  parameter  int N     = SA_N,
  parameter  int W     = SA_W,
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] psum_in,
  input  logic           in_valid,
  input  logic           relu_en,
  output logic [N*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LW-1:0]  fifo_level,
  output logic           overflow,
  input  logic           ovf_clr,
  output logic [15:0]    row_cnt
);
  logic [N-1:0][W-1:0] col_al, row_w;
  logic                wr_en, full, empty, push, pop;
  logic                ovf_q, ovf_d;
  logic [15:0]         row_cnt_q, row_cnt_d;

  // Column c arrives c cycles late, so it waits N-1-c cycles to line up with column N-1.
  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int D = N - 1 - c;
    if (D == 0) begin : g_pass
      assign col_al[c] = psum_in[c*W +: W];
    end else begin : g_dly
      logic [D-1:0][W-1:0] sk_q, sk_d;
      always_comb begin
        sk_d    = sk_q << W;
        sk_d[0] = psum_in[c*W +: W];
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sk_q <= '0;
        else      sk_q <= sk_d;
      end
      assign col_al[c] = sk_q[D-1];
    end
    assign row_w[c] = (relu_en && col_al[c][W-1]) ? '0 : col_al[c];
  end

  if (N == 1) begin : g_vld_none
    assign wr_en = in_valid;
  end else begin : g_vld
    logic [N-2:0] vld_pipe_q, vld_pipe_d;
    always_comb begin
      vld_pipe_d    = vld_pipe_q << 1;
      vld_pipe_d[0] = in_valid;
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_pipe_q <= '0;
      else      vld_pipe_q <= vld_pipe_d;
    end
    assign wr_en = vld_pipe_q[N-2];
  end

  assign pop  = out_valid && out_ready;
  assign push = wr_en && (!full || pop);

  sa_sync_fifo #(.WIDTH(N*W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .pop   (pop),
    .wdata (row_w),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d     = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (wr_en && full && !pop) ovf_d = 1'b1;
    row_cnt_d = row_cnt_q + 16'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q     <= 1'b0;
      row_cnt_q <= '0;
    end else begin
      ovf_q     <= ovf_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  assign out_valid = !empty;
  assign overflow  = ovf_q;
  assign row_cnt   = row_cnt_q;
endmodule

// File: tb/tb_sa_psum_collector.sv
// Bench for sa_psum_collector: skewed-row driver plus a queue-based reference of the row FIFO.
module tb_sa_psum_collector;
  import sa_pkg::*;

  localparam int N = 4, W = 32, DEPTH = 8, LW = $clog2(DEPTH + 1);
  typedef logic [N-1:0][W-1:0] row_t;

  logic           clk = 1'b0, rst = 1'b0;
  logic [N*W-1:0] psum_in = '0;
  logic           in_valid = 1'b0, relu_en = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic [N*W-1:0] out_data;
  logic           out_valid, overflow;
  logic [LW-1:0]  fifo_level;
  logic [15:0]    row_cnt;

  int n_cmp = 0, n_err = 0;

  // History of launched rows: index k = launched k cycles ago.
  bit   hv [N];
  row_t hr [N];
  row_t mq [$];
  bit   pp;
  row_t po, pe;

  sa_psum_collector #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .psum_in(psum_in), .in_valid(in_valid), .relu_en(relu_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr), .row_cnt(row_cnt)
  );

  always #5 clk = ~clk;

  function automatic row_t relu_row(input row_t r);
    for (int c = 0; c < N; c++) if (relu_en && r[c][W-1]) r[c] = '0;
    return r;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int c = 0; c < N; c++) r[c] = W'($urandom);
    return r;
  endfunction

  // One clock: launch row (column c appears c cycles later), update the reference queue.
  task automatic step(input bit v, input row_t row, input bit rdy,
                      output bit popped, output row_t obs, output row_t expd);
    bit room;
    for (int i = N - 1; i > 0; i--) begin hv[i] = hv[i-1]; hr[i] = hr[i-1]; end
    hv[0] = v; hr[0] = row;
    in_valid = v; out_ready = rdy;
    for (int c = 0; c < N; c++) psum_in[c*W +: W] = hv[c] ? hr[c][c] : W'($urandom);
    popped = rdy && (mq.size() > 0);
    obs    = out_data;
    expd   = popped ? mq[0] : '0;
    room   = (mq.size() < DEPTH) || popped;
    if (popped) void'(mq.pop_front());
    if (hv[N-1] && room) mq.push_back(relu_row(hr[N-1]));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, pp, po, pe);
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < N; i++) hv[i] = 1'b0;
    mq.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %0h exp 0", overflow); end
    n_cmp++; if (row_cnt !== '0) begin n_err++; $display("FAIL reset_row_cnt got %0d exp 0", row_cnt); end
    do_reset();
  endtask

  task automatic test_single_row();
    row_t r, exp1;
    exp1 = {32'h0800_0000, 32'h0600_0000, 32'h0400_0000, 32'h0200_0000};
    for (int c = 0; c < N; c++) r[c] = W'((c + 1) * ONE);
    step(1'b1, r, 1'b0, pp, po, pe);
    idle(N - 2, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %0h exp 0", out_valid); end
    idle(1, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0h exp 1", out_valid); end
    n_cmp++; if (out_data !== exp1) begin n_err++; $display("FAIL single_data got %h exp %h", out_data, exp1); end
    step(1'b0, '0, 1'b1, pp, po, pe);
    n_cmp++; if (row_cnt !== 16'd1) begin n_err++; $display("FAIL single_row_cnt got %0d exp 1", row_cnt); end
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL single_level got %0d exp 0", fifo_level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_after_pop got %0h exp 0", out_valid); end
  endtask

  task automatic test_relu();
    row_t r;
    r = rand_row();
    for (int c = 0; c < N; c++) r[c][W-1] = 1'b0;
    r[1] = 32'hFE00_0000;
    for (int k = 0; k < 2; k++) begin
      relu_en = (k == 0);
      step(1'b1, r, 1'b0, pp, po, pe);
      idle(N - 1, 1'b0);
      for (int c = 0; c < N; c++) begin
        logic [W-1:0] e;
        e = (c == 1 && k == 0) ? '0 : r[c];
        n_cmp++; if (out_data[c*W +: W] !== e) begin n_err++; $display("FAIL relu%0d_col%0d got %h exp %h", 1 - k, c, out_data[c*W +: W], e); end
      end
      step(1'b0, '0, 1'b1, pp, po, pe);
    end
  endtask

  task automatic test_overflow();
    row_t sent [9];
    relu_en = 1'b0;
    for (int i = 0; i < 9; i++) begin sent[i] = rand_row(); step(1'b1, sent[i], 1'b0, pp, po, pe); end
    idle(N - 1, 1'b0);
    n_cmp++; if (fifo_level !== LW'(DEPTH)) begin n_err++; $display("FAIL ovf_level got %0d exp %0d", fifo_level, DEPTH); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0h exp 1", overflow); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1, pp, po, pe);
      n_cmp++; if (po !== sent[i]) begin n_err++; $display("FAIL ovf_pop%0d got %h exp %h", i, po, sent[i]); end
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained got %0h exp 0", out_valid); end
    ovf_clr = 1'b1; idle(1, 1'b0); ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %0h exp 0", overflow); end
  endtask

  task automatic test_full_pop();
    row_t sent [9];
    for (int i = 0; i < 8; i++) begin sent[i] = rand_row(); step(1'b1, sent[i], 1'b0, pp, po, pe); end
    idle(N - 1, 1'b0);
    // Drop and clear land on the same edge: the flag must end up set.
    step(1'b1, rand_row(), 1'b0, pp, po, pe);
    idle(N - 2, 1'b0);
    ovf_clr = 1'b1; idle(1, 1'b0); ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL set_wins got %0h exp 1", overflow); end
    ovf_clr = 1'b1; idle(1, 1'b0); ovf_clr = 1'b0;
    sent[8] = rand_row();
    step(1'b1, sent[8], 1'b0, pp, po, pe);
    idle(N - 2, 1'b0);
    step(1'b0, '0, 1'b1, pp, po, pe);
    n_cmp++; if (po !== sent[0]) begin n_err++; $display("FAIL fullpop_head got %h exp %h", po, sent[0]); end
    n_cmp++; if (fifo_level !== LW'(DEPTH)) begin n_err++; $display("FAIL fullpop_level got %0d exp %0d", fifo_level, DEPTH); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf got %0h exp 0", overflow); end
    for (int i = 1; i < 9; i++) begin
      step(1'b0, '0, 1'b1, pp, po, pe);
      n_cmp++; if (po !== sent[i]) begin n_err++; $display("FAIL fullpop_order%0d got %h exp %h", i, po, sent[i]); end
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b1, rand_row(), 1'b0, pp, po, pe);
    idle(N - 1, 1'b0);
    step(1'b1, rand_row(), 1'b0, pp, po, pe);
    idle(2, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < N; i++) hv[i] = 1'b0;
    mq.delete();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %0h exp 0", out_valid); end
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL midrst_level got %0d exp 0", fifo_level); end
    n_cmp++; if (row_cnt !== '0) begin n_err++; $display("FAIL midrst_row_cnt got %0d exp 0", row_cnt); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL midrst_data got %h exp 0", out_data); end
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    idle(2 * N, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_ghost_valid got %0h exp 0", out_valid); end
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL midrst_ghost_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_streaming();
    row_t tx [$];
    int   recv = 0, steps = 0;
    do_reset();
    relu_en = 1'($urandom);
    while (recv < 100 && steps < 2000) begin
      bit   v, rdy;
      row_t r;
      v   = (tx.size() < 100);
      r   = rand_row();
      rdy = (mq.size() >= DEPTH) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL stream_valid got %0h exp %0h", out_valid, mq.size() > 0); end
      step(v, r, rdy, pp, po, pe);
      if (v) tx.push_back(r);
      if (pp) begin
        n_cmp++; if (po !== relu_row(tx[recv])) begin n_err++; $display("FAIL stream_row%0d got %h exp %h", recv, po, relu_row(tx[recv])); end
        recv++;
      end
      n_cmp++; if (fifo_level !== LW'(mq.size())) begin n_err++; $display("FAIL stream_level got %0d exp %0d", fifo_level, mq.size()); end
      steps++;
    end
    n_cmp++; if (recv != 100) begin n_err++; $display("FAIL stream_timeout got %0d exp 100", recv); end
    n_cmp++; if (row_cnt !== 16'd100) begin n_err++; $display("FAIL stream_row_cnt got %0d exp 100", row_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL stream_ovf got %0h exp 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_relu();
    test_overflow();
    test_full_pop();
    test_reset_midflight();
    test_streaming();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
